// File: rtl/sevseg_scan_ctrl_if.sv
// Avalon-MM slave register bus for the seven-segment scan controller.
// The master drives address and strobes, and the slave returns registered read data.
interface sevseg_scan_ctrl_if;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/sevseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with DATA/CTRL/STATUS registers.
// The shadow register reloads only on the frame wrap, so each frame is tear-free.
module sevseg_scan_ctrl #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  sevseg_scan_ctrl_if.slave    avs,
  output logic [6:0]           seg_n,
  output logic [3:0]           dig_en_n
);

  localparam int unsigned MAX_CYC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned TW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
  localparam logic [TW-1:0] DRIVE_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   data_q;
  logic          en_q, en_d;
  logic [3:0]    mask_q, mask_d;
  logic [6:0]    seg_d;
  logic [3:0]    dig_d;
  logic          wr_ctrl;
  logic [31:0]   rd_mux;
  logic          unused_wdata;

  assign unused_wdata = ^{avs.avs_writedata[31:16], avs.avs_writedata[3:1]};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    hex7 = 7'h7F;
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  // A CTRL write takes effect at the edge that samples it, so disabling blanks the very next cycle.
  always_comb begin
    wr_ctrl = avs.avs_write && (avs.avs_address == 2'd1);
    en_d    = wr_ctrl ? avs.avs_writedata[0]   : en_q;
    mask_d  = wr_ctrl ? avs.avs_writedata[7:4] : mask_q;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (avs.avs_address)
      2'd0:    rd_mux = {16'd0, data_q};
      2'd1:    rd_mux = {24'd0, mask_q, 3'd0, en_q};
      2'd2:    rd_mux = {28'd0, state_q == BLANK, state_q == DRIVE, idx_q};
      default: rd_mux = 32'd0;
    endcase
  end

  // Register file and registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q           <= 16'd0;
      en_q             <= 1'b0;
      mask_q           <= 4'd0;
      avs.avs_readdata <= 32'd0;
    end else begin
      en_q   <= en_d;
      mask_q <= mask_d;
      if (avs.avs_write && (avs.avs_address == 2'd0)) begin
        data_q <= avs.avs_writedata[15:0];
      end
      if (avs.avs_read) begin
        avs.avs_readdata <= rd_mux;
      end
    end
  end

  // FSM next state; outputs are decoded from next-state values so they line up with state_q.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    seg_d    = 7'h7F;
    dig_d    = 4'hF;

    if (!en_d) begin
      state_d = IDLE;
      timer_d = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = DRIVE;
          timer_d  = '0;
          idx_d    = 2'd0;
          shadow_d = data_q;
        end
        DRIVE: begin
          if (timer_q == DRIVE_LAST) begin
            state_d = BLANK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        BLANK: begin
          if (timer_q == BLANK_LAST) begin
            state_d = DRIVE;
            timer_d = '0;
            idx_d   = idx_q + 2'd1;
            // data_q still holds the pre-write value if a DATA write lands on this edge.
            if (idx_q == 2'd3) shadow_d = data_q;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
          idx_d   = 2'd0;
        end
      endcase
    end

    if (state_d == DRIVE) begin
      seg_d = hex7(shadow_d[{idx_d, 2'b00} +: 4]);
      dig_d = ~(4'b0001 << idx_d) | mask_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'd0;
      seg_n    <= 7'h7F;
      dig_en_n <= 4'hF;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_n    <= seg_d;
      dig_en_n <= dig_d;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Directed bench for sevseg_scan_ctrl with CLK_DIV=4, BLANK_CYCLES=2 (24-cycle frame).
// Tasks start and end on a falling edge; outputs are sampled there.
module tb_sevseg_scan_ctrl;
  logic       clk;
  logic       reset;
  logic [6:0] seg_n;
  logic [3:0] dig_en_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevseg_scan_ctrl_if bus ();

  sevseg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .avs      (bus),
    .seg_n    (seg_n),
    .dig_en_n (dig_en_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {dig_en_n, seg_n} at frame position k (digit = k/6, cycles 4..5 of each slot blank).
  function automatic logic [10:0] exp_out(input logic [15:0] d, input logic [3:0] mask, input int k);
    int digit;
    int c;
    logic [3:0] nib;
    logic [3:0] dig;
    digit = (k % 24) / 6;
    c     = k % 6;
    if (c >= 4) return {4'hF, 7'h7F};
    nib = d[digit*4 +: 4];
    dig = ~(4'b0001 << digit) | mask;
    return {dig, hex_tbl[nib]};
  endfunction

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.avs_address   = addr;
    bus.avs_writedata = data;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.avs_address = addr;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    data            = bus.avs_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (seg_n !== 7'h7F || dig_en_n !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%h expected 7f/f", seg_n, dig_en_n);
    end
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      bus_read(2'(a), rd);
      n_checks++;
      if (rd !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h expected 0", a, rd);
      end
    end
  endtask

  task automatic test_scan();
    logic [10:0] e;
    bus_write(2'd0, 32'h0000_1234);
    bus_write(2'd1, 32'h0000_0001);
    for (int k = 0; k < 48; k++) begin
      e = exp_out(16'h1234, 4'h0, k);
      n_checks++;
      if ({dig_en_n, seg_n} !== e) begin
        n_fail++;
        $display("FAIL scan k=%0d: got %h/%h expected %h/%h", k, dig_en_n, seg_n, e[10:7], e[6:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_frame_update();
    logic [10:0] e;
    repeat (6) @(negedge clk);
    bus_write(2'd0, 32'h0000_ABCD);
    for (int k = 7; k < 48; k++) begin
      e = exp_out((k < 24) ? 16'h1234 : 16'hABCD, 4'h0, k);
      n_checks++;
      if ({dig_en_n, seg_n} !== e) begin
        n_fail++;
        $display("FAIL frame_update k=%0d: got %h/%h expected %h/%h", k, dig_en_n, seg_n, e[10:7], e[6:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_blank_mask();
    logic [10:0] e;
    bus_write(2'd1, 32'h0000_0041);
    for (int k = 1; k < 48; k++) begin
      e = exp_out(16'hABCD, 4'h4, k);
      n_checks++;
      if ({dig_en_n, seg_n} !== e) begin
        n_fail++;
        $display("FAIL blank_mask k=%0d: got %h/%h expected %h/%h", k, dig_en_n, seg_n, e[10:7], e[6:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_disable();
    logic [31:0] rd;
    logic [10:0] e;
    repeat (2) @(negedge clk);
    bus_write(2'd1, 32'h0000_0000);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (seg_n !== 7'h7F || dig_en_n !== 4'hF) begin
        n_fail++;
        $display("FAIL disable_off i=%0d: got %h/%h expected 7f/f", i, seg_n, dig_en_n);
      end
      @(negedge clk);
    end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++;
      $display("FAIL disable_status: got %h expected 0", rd);
    end
    bus_write(2'd1, 32'h0000_0001);
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++;
      $display("FAIL restart_status: got %h expected 4", rd);
    end
    for (int k = 1; k < 24; k++) begin
      e = exp_out(16'hABCD, 4'h0, k);
      n_checks++;
      if ({dig_en_n, seg_n} !== e) begin
        n_fail++;
        $display("FAIL restart k=%0d: got %h/%h expected %h/%h", k, dig_en_n, seg_n, e[10:7], e[6:0]);
      end
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'h9) begin
      n_fail++;
      $display("FAIL blank_status: got %h expected 9", rd);
    end
  endtask

  task automatic test_reset_mid_drive();
    logic [31:0] rd;
    bus_write(2'd1, 32'h0000_0000);
    bus_write(2'd0, 32'h0000_1234);
    bus_write(2'd1, 32'h0000_0001);
    repeat (2) @(negedge clk);
    n_checks++;
    if (dig_en_n !== 4'hE || seg_n !== 7'h19) begin
      n_fail++;
      $display("FAIL pre_reset_drive: got %h/%h expected e/19", dig_en_n, seg_n);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (seg_n !== 7'h7F || dig_en_n !== 4'hF) begin
      n_fail++;
      $display("FAIL async_reset_off: got %h/%h expected 7f/f", seg_n, dig_en_n);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (seg_n !== 7'h7F || dig_en_n !== 4'hF) begin
        n_fail++;
        $display("FAIL post_reset_idle i=%0d: got %h/%h expected 7f/f", i, seg_n, dig_en_n);
      end
      @(negedge clk);
    end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_status: got %h expected 0", rd);
    end
  endtask

  task automatic test_reset_mid_blank();
    logic [31:0] rd;
    bus_write(2'd0, 32'h0000_5678);
    bus_write(2'd1, 32'h0000_0001);
    repeat (22) @(negedge clk);
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'hB) begin
      n_fail++;
      $display("FAIL blank3_status: got %h expected b", rd);
    end
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      bus_read(2'(a), rd);
      n_checks++;
      if (rd !== 32'd0) begin
        n_fail++;
        $display("FAIL blank_reset_reg%0d: got %h expected 0", a, rd);
      end
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (seg_n !== 7'h7F || dig_en_n !== 4'hF) begin
        n_fail++;
        $display("FAIL blank_reset_off i=%0d: got %h/%h expected 7f/f", i, seg_n, dig_en_n);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'h0000_FFFF) begin
      n_fail++;
      $display("FAIL data_upper_zero: got %h expected 0000ffff", rd);
    end
    bus_write(2'd1, 32'hFFFF_FFF0);
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h0000_00F0) begin
      n_fail++;
      $display("FAIL ctrl_readback: got %h expected 000000f0", rd);
    end
    bus.avs_address = 2'd3;
    bus.avs_read    = 1'b1;
    #1;
    n_checks++;
    if (bus.avs_readdata !== 32'h0000_00F0) begin
      n_fail++;
      $display("FAIL read_latency: got %h expected 000000f0 before edge", bus.avs_readdata);
    end
    @(negedge clk);
    bus.avs_read = 1'b0;
    n_checks++;
    if (bus.avs_readdata !== 32'd0) begin
      n_fail++;
      $display("FAIL addr3_read: got %h expected 0", bus.avs_readdata);
    end
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'h1234_5678);
    bus_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'h0000_FFFF) begin
      n_fail++;
      $display("FAIL ignored_writes_data: got %h expected 0000ffff", rd);
    end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++;
      $display("FAIL ignored_writes_status: got %h expected 0", rd);
    end
    n_checks++;
    if (seg_n !== 7'h7F || dig_en_n !== 4'hF) begin
      n_fail++;
      $display("FAIL disabled_outputs: got %h/%h expected 7f/f", seg_n, dig_en_n);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus.avs_address   = 2'd0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = 32'd0;
    bus.avs_read      = 1'b0;
    test_reset();
    test_scan();
    test_frame_update();
    test_blank_mask();
    test_disable();
    test_reset_mid_drive();
    test_reset_mid_blank();
    test_regs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevseg_scan_ctrl.md
SEVSEG_SCAN_CTRL -- requirements
Module: sevseg_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-002 Parameter CLK_DIV, default 50000, SHALL set the number of clk cycles each digit is driven (minimum 2).
REQ-003 Parameter BLANK_CYCLES, default 16, SHALL set the number of clk cycles all digits are off between digits (minimum 1).
REQ-004 Port clk, input, 1 bit: system clock.
REQ-005 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 Port avs_address, input, 2 bits: register select (0 DATA, 1 CTRL, 2 STATUS, 3 reserved).
REQ-007 Port avs_write, input, 1 bit: write strobe, single-cycle.
REQ-008 Port avs_writedata, input, 32 bits: write data.
REQ-009 Port avs_read, input, 1 bit: read strobe, single-cycle.
REQ-010 Port avs_readdata, output, 32 bits: registered read data.
REQ-011 Port seg_n, output, 7 bits: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-012 Port dig_en_n, output, 4 bits: active-low digit enables; bit i is digit i.

Function
REQ-013 DATA[15:0] SHALL hold four hex nibbles; nibble i (bits 4i+3:4i) maps to digit i. Bits 31:16 SHALL read as 0.
REQ-014 CTRL bit0 (EN) SHALL enable scanning. CTRL bits 7:4 (BLANK_MASK) SHALL force digit i off when bit 4+i is 1. Other bits SHALL read as 0.
REQ-015 STATUS SHALL be read-only: bits 1:0 hold the current digit index, bit 2 is 1 in DRIVE, and bit 3 is 1 in BLANK.
REQ-016 A read SHALL return data on avs_readdata exactly 1 cycle after avs_read. Reads of address 3 SHALL return 0. Writes to addresses 2 and 3 SHALL be ignored.
REQ-017 The FSM SHALL have three states: IDLE, DRIVE and BLANK.
REQ-018 IDLE: seg_n SHALL be 7'h7F and dig_en_n SHALL be 4'hF. When EN=1, the FSM SHALL move to DRIVE with idx=0 and load the shadow register from DATA.
REQ-019 DRIVE: the FSM SHALL stay for exactly CLK_DIV cycles. It SHALL assert dig_en_n[idx]=0 unless BLANK_MASK[idx]=1. seg_n SHALL be the hex decode of shadow nibble idx.
REQ-020 BLANK: the FSM SHALL stay for exactly BLANK_CYCLES cycles with dig_en_n=4'hF and seg_n=7'h7F. It SHALL then increment idx, wrapping 3 to 0, and return to DRIVE.
REQ-021 On the 3-to-0 wrap, the shadow register SHALL load from DATA (tear-free frame update).
REQ-022 If a DATA write and the wrap occur in the same cycle, the shadow SHALL load the pre-write value. The new value SHALL take effect in the next frame.
REQ-023 EN=0 SHALL force the FSM to IDLE on the next clock from any state. The timer and idx SHALL clear. seg_n and dig_en_n SHALL be off in the cycle after the write.
REQ-024 The hex decode (active-low) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-025 seg_n and dig_en_n SHALL be registered outputs, with no combinational path from the Avalon inputs.
REQ-026 The cycle timer SHALL be wide enough for max(CLK_DIV, BLANK_CYCLES) and SHALL never wrap within a state.

Reset
REQ-027 Reset SHALL asynchronously clear DATA, CTRL, the shadow register, idx, the timer and avs_readdata to 0, and set the FSM to IDLE.
REQ-028 During reset, seg_n SHALL be 7'h7F and dig_en_n SHALL be 4'hF.
REQ-029 A reset asserted mid-DRIVE SHALL turn outputs off immediately. After release, the FSM SHALL wait in IDLE until EN is written.

Verification (CLK_DIV=4, BLANK_CYCLES=2)
REQ-030 Write DATA=0x1234, then CTRL=0x1 -> dig_en_n=E with seg_n=19 for 4 cycles, then F/7F for 2 cycles, then D/30, then B/24, then 7/79, then repeat.
REQ-031 Write DATA=0xABCD during digit 1 of a frame -> the remainder of the frame shows the old nibbles; the next frame shows digit0=21 (d), digit1=46 (C), digit2=03 (b), digit3=08 (A).
REQ-032 Write CTRL=0x41 -> digit 2 never asserts dig_en_n[2]=0, but its DRIVE and BLANK timing is unchanged.
REQ-033 Write CTRL=0x0 mid-DRIVE -> next cycle outputs F/7F and STATUS reads 0. Re-enabling restarts at digit 0.
REQ-034 Assert reset mid-BLANK of digit 3 -> DATA, CTRL and STATUS read 0 after release, and the outputs stay off.
REQ-035 Read each address -> data appears 1 cycle after avs_read; address 3 returns 0, and DATA[31:16] returns 0 after a write of 0xFFFFFFFF.
